// File: rtl/univ_shift_reg_pkg.sv
// Mode encodings for the universal shift register and related lab blocks.
// Pure definitions: no latency, no flow control.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_LOAD  = 3'b001;
  localparam mode_t MODE_SHL   = 3'b010;
  localparam mode_t MODE_SHR   = 3'b011;
  localparam mode_t MODE_ROL   = 3'b100;
  localparam mode_t MODE_ROR   = 3'b101;
  localparam mode_t MODE_ASR   = 3'b110;
  localparam mode_t MODE_CLEAR = 3'b111;

endpackage

// File: rtl/univ_shift_reg_counter.sv
// Saturating serial-shift counter: Full at MAX, one-cycle Done pulse on reaching it.
// Latency 1 cycle from Inc/Clr to Full/Done; no backpressure, every edge is accepted.
module shift_counter #(
  parameter int MAX = 8
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic Inc,
  input  logic Clr,
  output logic Full,
  output logic Done
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);

  logic [CW-1:0] cnt;

  // Done only fires on the MAX-1 -> MAX transition, never while already saturated.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt  <= '0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Clr) begin
        cnt <= '0;
      end else if (Inc && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) Done <= 1'b1;
      end
    end
  end

  assign Full = (cnt == CNT_MAX);

endmodule

// File: rtl/univ_shift_reg.sv
// N-bit universal register: load, shifts, rotates, arithmetic shift, clear.
// Latency 1 cycle from Mode/En to Q; no backpressure, En=0 simply holds.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic             SerInL,
  input  logic             SerInR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic             Full,
  output logic             Done
);

  logic [WIDTH-1:0] q_nxt;
  logic             cnt_inc;
  logic             cnt_clr;

  always_comb begin
    q_nxt = Q;
    if (En) begin
      case (Mode)
        MODE_LOAD:  q_nxt = D;
        MODE_SHL:   q_nxt = {Q[WIDTH-2:0], SerInR};
        MODE_SHR:   q_nxt = {SerInL, Q[WIDTH-1:1]};
        MODE_ROL:   q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR:   q_nxt = {Q[0], Q[WIDTH-1:1]};
        MODE_ASR:   q_nxt = {Q[WIDTH-1], Q[WIDTH-1:1]};
        MODE_CLEAR: q_nxt = RESET_VAL;
        default:    q_nxt = Q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) Q <= RESET_VAL;
    else         Q <= q_nxt;
  end

  // Only shifts that bring in new serial data advance the count.
  assign cnt_inc = En && ((Mode == MODE_SHL) || (Mode == MODE_SHR));
  assign cnt_clr = En && ((Mode == MODE_LOAD) || (Mode == MODE_CLEAR));

  shift_counter #(.MAX(WIDTH)) u_cnt (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Inc    (cnt_inc),
    .Clr    (cnt_clr),
    .Full   (Full),
    .Done   (Done)
  );

  assign SerOutL = Q[WIDTH-1];
  assign SerOutR = Q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboarded directed test of univ_shift_reg at WIDTH=8, RESET_VAL=0.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Resetn = 1'b1;
  logic         En = 1'b0;
  logic [2:0]   Mode = MODE_HOLD;
  logic         SerInL = 1'b0;
  logic         SerInR = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q;
  logic         SerOutL, SerOutR, Full, Done;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .Clk(Clk), .Resetn(Resetn), .En(En), .Mode(Mode),
    .SerInL(SerInL), .SerInR(SerInR), .D(D),
    .Q(Q), .SerOutL(SerOutL), .SerOutR(SerOutR), .Full(Full), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] q;
    logic         full;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [W-1:0] q, input logic fl, input logic dn);
    total = total + 1;
    if (Q !== q || Full !== fl || Done !== dn || SerOutL !== q[W-1] || SerOutR !== q[0]) begin
      bad = bad + 1;
      $display("FAIL %s @cyc%0d: got Q=%h Full=%b Done=%b SL=%b SR=%b, want Q=%h Full=%b Done=%b SL=%b SR=%b",
               name, cyc, Q, Full, Done, SerOutL, SerOutR, q, fl, dn, q[W-1], q[0]);
    end
  endtask

  // Monitor: compare every expectation due in the cycle just completed.
  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL stale_entry: expected at cyc%0d, got to it at cyc%0d", e.cyc, cyc);
      end else begin
        check("sb", e.q, e.full, e.done);
      end
    end
  end

  // Apply one operation for the next edge and queue its expected result.
  task automatic op(input logic en, input logic [2:0] md, input logic sl, input logic sr,
                    input logic [W-1:0] d, input logic [W-1:0] eq, input logic ef, input logic ed);
    exp_t e;
    @(posedge Clk);
    #1;
    En = en; Mode = md; SerInL = sl; SerInR = sr; D = d;
    e.cyc = cyc + 1; e.q = eq; e.full = ef; e.done = ed;
    exp_q.push_back(e);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Mid-cycle asynchronous reset pulse, checked without any clock edge.
  task automatic reset_pulse(input string name);
    drain();
    En = 1'b0; Mode = MODE_HOLD;
    Resetn = 1'b0;
    #1;
    check(name, 8'h00, 1'b0, 1'b0);
    #2;
    Resetn = 1'b1;
  endtask

  logic [7:0] shl_bits;
  logic [7:0] shl_q [8];
  logic [7:0] shr_q [8];
  logic [7:0] one_q [8];

  initial begin
    shl_bits = 8'b1011_0010;
    shl_q = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    shr_q = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    one_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    #2 Resetn = 1'b0;
    #1 check("por_async", 8'h00, 1'b0, 1'b0);
    #12 Resetn = 1'b1;

    // Load, then abort with an asynchronous reset mid-cycle.
    op(1, MODE_LOAD, 0, 0, 8'h3C, 8'h3C, 0, 0);
    reset_pulse("midcycle_reset");
    op(0, MODE_LOAD, 0, 0, 8'hFF, 8'h00, 0, 0);
    op(0, MODE_LOAD, 0, 0, 8'hFF, 8'h00, 0, 0);

    // Parallel load and En=0 hold across shift modes.
    op(1, MODE_LOAD, 0, 0, 8'hA5, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) op(0, MODE_SHL, 1, 1, 8'h00, 8'hA5, 0, 0);
    op(0, MODE_CLEAR, 0, 0, 8'h00, 8'hA5, 0, 0);

    // Serial assembly via SHL; Done on the 8th shift only.
    op(1, MODE_CLEAR, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++)
      op(1, MODE_SHL, 0, shl_bits[7-i], 8'h00, shl_q[i], (i == 7), (i == 7));
    op(1, MODE_SHL, 0, 0, 8'h00, 8'h64, 1, 0);
    op(1, MODE_ROR, 0, 0, 8'h00, 8'h32, 1, 0);
    op(1, MODE_HOLD, 0, 0, 8'h00, 8'h32, 1, 0);

    // Rotates leave the count alone.
    op(1, MODE_LOAD, 0, 0, 8'h81, 8'h81, 0, 0);
    op(1, MODE_ROL, 0, 0, 8'h00, 8'h03, 0, 0);
    op(1, MODE_ROR, 0, 0, 8'h00, 8'h81, 0, 0);
    op(1, MODE_ROR, 0, 0, 8'h00, 8'hC0, 0, 0);

    // Arithmetic shift right propagates the sign bit.
    op(1, MODE_LOAD, 0, 0, 8'h90, 8'h90, 0, 0);
    op(1, MODE_ASR, 1, 1, 8'h00, 8'hC8, 0, 0);
    op(1, MODE_ASR, 0, 0, 8'h00, 8'hE4, 0, 0);
    op(1, MODE_LOAD, 0, 0, 8'h10, 8'h10, 0, 0);
    op(1, MODE_ASR, 1, 1, 8'h00, 8'h08, 0, 0);

    // Partial SHR count, reset, then a full count from zero.
    op(1, MODE_CLEAR, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) op(1, MODE_SHR, 1, 0, 8'h00, shr_q[i], 0, 0);
    reset_pulse("reset_abort_shift");
    for (int i = 0; i < 8; i++)
      op(1, MODE_SHR, 1, 0, 8'h00, shr_q[i], (i == 7), (i == 7));
    op(1, MODE_HOLD, 0, 0, 8'h00, 8'hFF, 1, 0);

    // CLEAR re-arms Done for another full word.
    op(1, MODE_CLEAR, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++)
      op(1, MODE_SHL, 0, 1, 8'h00, one_q[i], (i == 7), (i == 7));
    op(0, MODE_SHL, 0, 1, 8'h00, 8'hFF, 1, 0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised N-bit universal register, the successor to the lab single-bit D latch and flip-flops.
- Edge-triggered storage with enable, parallel load, logical/arithmetic shifts, rotates and synchronous clear.
- A shift counter flags when a full word has been serially assembled.
- Sits between switch/serial inputs and LED/HEX display logic in lab top levels.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into Q on reset and on CLEAR.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Resetn  input  1  asynchronous active-low reset.
- En  input  1  operation enable; when 0 the register holds regardless of Mode.
- Mode  input  3  operation select (see Behaviour).
- SerInL  input  1  serial bit entering at MSB on right shifts.
- SerInR  input  1  serial bit entering at LSB on left shifts.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- SerOutL  output  1  Q[WIDTH-1], combinational from Q.
- SerOutR  output  1  Q[0], combinational from Q.
- Full  output  1  high when the shift count equals WIDTH.
- Done  output  1  one-cycle pulse on the cycle Full first rises.

Behaviour:
- One clock, Clk. Reset is asynchronous and active-low on Resetn.
- On Resetn=0, immediately: Q=RESET_VAL, ShiftCnt=0, Full=0, Done=0. Reset mid-operation aborts any shift sequence.
- All updates occur on the rising Clk edge when Resetn=1. Latency is 1 cycle from Mode/En sampled to new Q.
- Mode encoding, acting only when En=1:
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q=D.
  - 010 SHL: Q={Q[WIDTH-2:0],SerInR}.
  - 011 SHR: Q={SerInL,Q[WIDTH-1:1]}.
  - 100 ROL: Q={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 101 ROR: Q={Q[0],Q[WIDTH-1:1]}.
  - 110 ASR: Q={Q[WIDTH-1],Q[WIDTH-1:1]}.
  - 111 CLEAR: Q=RESET_VAL.
- En=0 behaves as HOLD for every Mode. The counter is also unchanged.
- ShiftCnt, internal, width $clog2(WIDTH+1):
  - SHL and SHR increment it, saturating at WIDTH.
  - ROL, ROR and ASR do not change it (no new data enters).
  - LOAD and CLEAR reset it to 0.
  - HOLD leaves it unchanged.
- Full = (ShiftCnt==WIDTH), registered with the count.
- Done is 1 for exactly the cycle after the edge where ShiftCnt goes WIDTH-1 -> WIDTH.
  - Further shifts while saturated give Full=1, Done=0.
  - A LOAD or CLEAR followed by WIDTH shifts produces a new Done pulse.
- Boundary rules:
  - Shifting with SerIn=X is the user's responsibility; no checking.
  - Mode changes every cycle are legal; no internal state beyond Q and ShiftCnt.
  - With WIDTH=2, all modes remain well defined.
- No latches. Q must be a true edge register.

Decomposition:
- Package usr_pkg holds the mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLEAR. Shared with future lab blocks (e.g. an LFSR wrapper).
- One sub-module, shift_counter, parameterised by MAX=WIDTH.
  - Inputs: Clk, Resetn, Inc, Clr.
  - Outputs: Full, Done.
  - Implements saturating count and the Done pulse.
- Top level is the data path mux plus the Q register.

Test Plan:
- WIDTH=8: Resetn low mid-cycle -> Q=00 asynchronously, Full=0, Done=0; released, Q holds 00 until En=1.
- LOAD D=A5 -> Q=A5 next cycle, SerOutL=1, SerOutR=1; then En=0 with Mode=SHL for 3 cycles -> Q stays A5.
- CLEAR, then 8x SHL with SerInR pattern 1,0,1,1,0,0,1,0 -> Q=B2. Done pulses once after the 8th edge, Full=1; a 9th SHL keeps Full=1, Done=0.
- LOAD 81 then ROL -> 03; ROR -> 81; ROR -> C0; ShiftCnt stays 0, Full=0 throughout.
- LOAD 90 then ASR -> C8, ASR -> E4; LOAD 10, ASR -> 08 (sign propagation).
- SHR x4 with SerInL=1 from Q=00, then Resetn pulse low, then 8x SHR -> Done pulses only after the full 8 post-reset shifts (reset clears the partial count).
